// File: rtl/axi_timer.sv
// AXI4-Lite programmable timer: 16-bit prescaler feeding a 32-bit counter with
// compare match, optional auto-reload and a registered level interrupt.
module axi_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    irq
);
    localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] A_CTRL      = 3'd0;
    localparam logic [2:0] A_PRESCALE  = 3'd1;
    localparam logic [2:0] A_COUNT     = 3'd2;
    localparam logic [2:0] A_COMPARE   = 3'd3;
    localparam logic [2:0] A_STATUS    = 3'd4;

    // Timer state
    logic [2:0]            ctrl_q, ctrl_d;
    logic [15:0]           prescale_q, prescale_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic                  match_q, match_d;
    logic [15:0]           presc_q, presc_d;
    logic                  irq_q;

    // Bus state
    logic                  aw_q, w_q;
    logic [11:2]           awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  unused_bits;
    assign unused_bits = ^{awaddr, araddr, awprot, arprot};

    function automatic logic is_mapped(input logic [11:2] a);
        return (a[11:5] == 7'd0) && (a[4:2] <= A_STATUS);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_mux(input logic [11:2] a);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (a[11:5] == 7'd0) begin
            case (a[4:2])
                A_CTRL:     v[2:0]  = ctrl_q;
                A_PRESCALE: v[15:0] = prescale_q;
                A_COUNT:    v       = count_q;
                A_COMPARE:  v       = compare_q;
                A_STATUS:   v[0]    = match_q;
                default:    v       = '0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] nw,
                                                    input logic [STRB_WIDTH-1:0] strb);
        logic [DATA_WIDTH-1:0] v;
        for (int b = 0; b < STRB_WIDTH; b++)
            v[b*8 +: 8] = strb[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
        return v;
    endfunction

    // Channel handshakes; a write fires as soon as both halves are available,
    // whether latched earlier or arriving this cycle.
    logic                  aw_hs, w_hs, ar_hs, wr_fire, wr_ok;
    logic [11:2]           wr_addr;
    logic [DATA_WIDTH-1:0] wr_data, wr_merged;
    logic [STRB_WIDTH-1:0] wr_strb;

    assign awready = ~rst & ~aw_q & ~bvalid_q;
    assign wready  = ~rst & ~w_q & ~bvalid_q;
    assign arready = ~rst & ~rvalid_q;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign ar_hs   = arvalid & arready;
    assign wr_fire = (aw_q | aw_hs) & (w_q | w_hs);
    assign wr_addr = aw_q ? awaddr_q : awaddr[11:2];
    assign wr_data = w_q ? wdata_q : wdata;
    assign wr_strb = w_q ? wstrb_q : wstrb;
    assign wr_ok   = wr_fire & is_mapped(wr_addr);

    logic tick, hit;
    assign tick = ctrl_q[0] && (presc_q == prescale_q);
    assign hit  = tick && (count_q == compare_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        match_d    = match_q;
        wr_merged  = merge(rd_mux(wr_addr), wr_data, wr_strb);
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        count_d    = count_q;
        if (tick)
            count_d = (hit && ctrl_q[1]) ? '0 : count_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        if (wr_ok) begin
            case (wr_addr[4:2])
                A_CTRL:     ctrl_d     = wr_merged[2:0];
                A_PRESCALE: prescale_d = wr_merged[15:0];
                A_COUNT: begin
                    count_d = wr_merged;
                    presc_d = 16'd0;
                end
                A_COMPARE:  compare_d  = wr_merged;
                A_STATUS:   if (wr_strb[0] && wr_data[0]) match_d = 1'b0;
                default: ;
            endcase
        end
        // A fresh match beats a same-cycle clear
        if (hit) match_d = 1'b1;
        // Prescaler restarts from 0 whenever the timer is (or becomes) stopped
        if (!ctrl_q[0] || !ctrl_d[0]) presc_d = 16'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
            presc_q    <= '0;
            irq_q      <= 1'b0;
            aw_q       <= 1'b0;
            w_q        <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            presc_q    <= presc_d;
            irq_q      <= match_q & ctrl_q[2];

            if (wr_fire) begin
                aw_q     <= 1'b0;
                w_q      <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= is_mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_q     <= 1'b1;
                    awaddr_q <= awaddr[11:2];
                end
                if (w_hs) begin
                    w_q     <= 1'b1;
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                end
                if (bvalid_q && bready) bvalid_q <= 1'b0;
            end

            // Read samples register state before this cycle's write lands
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux(araddr[11:2]);
                rresp_q  <= is_mapped(araddr[11:2]) ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_axi_timer.sv
// Directed self-checking bench for axi_timer: register access, handshakes,
// prescaled counting, match/W1C interplay and reset mid-transaction.
module tb_axi_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("wr_addr_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("wr_resp_timeout", 0, 1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("rd_addr_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 0; rready = 1;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("rd_data_timeout", 0, 1);
        d = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 0;
    endtask

    initial begin
        logic [31:0] d, d2;
        logic [1:0]  r, r2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {26'd0, awready, wready, arready, bvalid, rvalid, irq}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_resp", {28'd0, bresp, rresp}, 32'h0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", {29'd0, awready, wready, arready}, 32'h7);
        @(posedge clk); #1;
        axi_rd(32'h08, d, r);
        chk("count_rst", d, 32'h0);

        // Prescale 3, compare 5, auto-reload with irq
        axi_wr(32'h04, 32'h3, 4'hF, r);
        axi_wr(32'h0C, 32'h5, 4'hF, r);
        axi_wr(32'h00, 32'h7, 4'hF, r);
        repeat (2) @(posedge clk); #1;
        axi_rd(32'h08, d, r);
        chk("count_before_tick", d, 32'h0);
        axi_rd(32'h08, d, r);
        chk("count_first_tick", d, 32'h1);
        repeat (17) @(posedge clk); #1;
        chk("irq_at_match", irq, 0);
        @(posedge clk); #1;
        chk("irq_after_match", irq, 1);
        axi_rd(32'h08, d, r);
        chk("count_reloaded", d, 32'h0);
        axi_rd(32'h10, d, r);
        chk("status_match", d, 32'h1);
        axi_wr(32'h00, 32'h0, 4'hF, r);
        chk("irq_en_off", irq, 0);
        axi_wr(32'h10, 32'h1, 4'h1, r);
        axi_rd(32'h10, d, r);
        chk("status_w1c", d, 32'h0);

        // W1C coinciding with a match tick, then on a non-match cycle
        axi_wr(32'h04, 32'h0, 4'hF, r);
        axi_wr(32'h0C, 32'h1, 4'hF, r);
        axi_wr(32'h08, 32'h0, 4'hF, r);
        axi_wr(32'h00, 32'h5, 4'hF, r);
        axi_wr(32'h10, 32'h1, 4'hF, r);
        chk("irq_set_wins", irq, 1);
        axi_rd(32'h10, d, r);
        chk("status_set_wins", d, 32'h1);
        axi_wr(32'h10, 32'h1, 4'hF, r);
        chk("irq_cleared", irq, 0);
        axi_rd(32'h10, d, r);
        chk("status_cleared", d, 32'h0);
        axi_wr(32'h00, 32'h0, 4'hF, r);

        // W three cycles ahead of AW, byte-lane write, stalled response
        axi_wr(32'h0C, 32'h12345678, 4'hF, r);
        wdata = 32'h0000AB00; wstrb = 4'h2; wvalid = 1;
        @(posedge clk); #1;
        wvalid = 0;
        chk("wready_latched", wready, 0);
        chk("awready_indep", awready, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bvalid_no_aw", bvalid, 0);
        awaddr = 32'h0C; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        chk("bvalid_after_aw", bvalid, 1);
        chk("bresp_okay", bresp, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        chk("bvalid_hold", bvalid, 1);
        chk("awready_blocked", awready, 0);
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        chk("bvalid_drop", bvalid, 0);
        axi_rd(32'h0C, d, r);
        chk("compare_bytelane", d, 32'h1234AB78);

        // Unmapped and aliased addresses
        axi_rd(32'h18, d, r);
        chk("unmapped_rdata", d, 32'h0);
        chk("unmapped_rresp", r, 2'b10);
        axi_wr(32'h40, 32'hFFFFFFFF, 4'hF, r);
        chk("unmapped_bresp", r, 2'b10);
        axi_rd(32'h00, d, r);
        chk("ctrl_untouched", d, 32'h0);
        axi_rd(32'h0C, d, r);
        chk("compare_untouched", d, 32'h1234AB78);
        chk("mapped_rresp", r, 2'b00);
        axi_wr(32'h1004, 32'hFFFF0007, 4'hF, r);
        chk("alias_bresp", r, 2'b00);
        axi_rd(32'h04, d, r);
        chk("prescale_reserved", d, 32'h7);

        // Concurrent read and write of the same register
        fork
            axi_wr(32'h04, 32'h9, 4'hF, r);
            axi_rd(32'h04, d2, r2);
        join
        chk("rd_pre_write", d2, 32'h7);
        axi_rd(32'h04, d, r);
        chk("rd_post_write", d, 32'h9);

        // Counter wrap with no match
        axi_wr(32'h04, 32'h0, 4'hF, r);
        axi_wr(32'h0C, 32'h10, 4'hF, r);
        axi_wr(32'h08, 32'hFFFFFFFE, 4'hF, r);
        axi_wr(32'h00, 32'h1, 4'hF, r);
        axi_rd(32'h08, d, r);
        chk("count_max", d, 32'hFFFFFFFF);
        axi_rd(32'h08, d, r);
        chk("count_wrapped", d, 32'h1);
        axi_rd(32'h10, d, r);
        chk("wrap_no_match", d, 32'h0);
        axi_wr(32'h00, 32'h0, 4'hF, r);

        // Reset during a pending response with the counter running
        axi_wr(32'h08, 32'h0, 4'hF, r);
        axi_wr(32'h0C, 32'h3, 4'hF, r);
        axi_wr(32'h00, 32'h7, 4'hF, r);
        repeat (4) @(posedge clk);
        #1;
        chk("irq_before_rst", irq, 1);
        awaddr = 32'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        chk("bvalid_pending", bvalid, 1);
        rst = 1;
        #1;
        chk("arready_in_rst", arready, 0);
        @(posedge clk); #1;
        rst = 0;
        chk("bvalid_rst", bvalid, 0);
        chk("irq_rst", irq, 0);
        axi_rd(32'h08, d, r);
        chk("count_rst2", d, 32'h0);
        axi_rd(32'h00, d, r);
        chk("ctrl_rst2", d, 32'h0);
        axi_rd(32'h0C, d, r);
        chk("compare_rst2", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
